// File: rtl/l1_l2_miss_port_if.sv
// Channel bundle between the L1-side miss port and its surroundings
// (L1 cache on one side, l2cache_pipe on the other).
//
// Handshake rule for every valid/retry channel: the sender raises valid and
// holds the payload stable; a transfer happens on a clock edge where
// valid && !retry. The receiver may assert retry at any time.
// snoop_inv is a plain one-cycle pulse with no retry.
interface l1_l2_miss_port_if #(
  parameter int L1ID_W  = 5,
  parameter int L2ID_W  = 6,
  parameter int LADDR_W = 39,
  parameter int PADDR_W = 50,
  parameter int LINE_W  = 512,
  parameter int CMD_W   = 3,
  parameter int DCMD_W  = 3,
  parameter int SNACK_W = 5,
  parameter int PC_W    = 13,
  parameter int SPTBR_W = 38,
  parameter int MASK_W  = 16
);
  // L1 miss request
  logic               miss_valid;
  logic               miss_retry;
  logic [CMD_W-1:0]   miss_cmd;
  logic [PC_W-1:0]    miss_pcsign;
  logic [LADDR_W-1:0] miss_laddr;
  logic [SPTBR_W-1:0] sptbr;
  // request to L2
  logic               l1tol2_req_valid;
  logic               l1tol2_req_retry;
  logic [L1ID_W-1:0]  l1tol2_req_dcid;
  logic [CMD_W-1:0]   l1tol2_req_cmd;
  logic [PC_W-1:0]    l1tol2_req_pcsign;
  logic [LADDR_W-1:0] l1tol2_req_laddr;
  logic [SPTBR_W-1:0] l1tol2_req_sptbr;
  // snack from L2
  logic               l2tol1_snack_valid;
  logic               l2tol1_snack_retry;
  logic [L1ID_W-1:0]  l2tol1_snack_dcid;
  logic [L2ID_W-1:0]  l2tol1_snack_l2id;
  logic [SNACK_W-1:0] l2tol1_snack_snack;
  logic [LINE_W-1:0]  l2tol1_snack_line;
  logic [PADDR_W-1:0] l2tol1_snack_paddr;
  // snoop ack to L2
  logic               l1tol2_snoop_ack_valid;
  logic               l1tol2_snoop_ack_retry;
  logic [L2ID_W-1:0]  l1tol2_snoop_ack_l2id;
  // fill to L1
  logic               fill_valid;
  logic               fill_retry;
  logic [L1ID_W-1:0]  fill_id;
  logic [SNACK_W-1:0] fill_snack;
  logic [LINE_W-1:0]  fill_line;
  logic [PADDR_W-1:0] fill_paddr;
  // snoop invalidate to L1
  logic               snoop_inv_valid;
  logic [PADDR_W-1:0] snoop_inv_paddr;
  // eviction from L1
  logic               evict_valid;
  logic               evict_retry;
  logic [L2ID_W-1:0]  evict_l2id;
  logic [DCMD_W-1:0]  evict_dcmd;
  logic [LINE_W-1:0]  evict_line;
  logic [PADDR_W-1:0] evict_paddr;
  // displacement to L2
  logic               l1tol2_disp_valid;
  logic               l1tol2_disp_retry;
  logic [L1ID_W-1:0]  l1tol2_disp_l1id;
  logic [L2ID_W-1:0]  l1tol2_disp_l2id;
  logic [MASK_W-1:0]  l1tol2_disp_mask;
  logic [DCMD_W-1:0]  l1tol2_disp_dcmd;
  logic [LINE_W-1:0]  l1tol2_disp_line;
  logic [PADDR_W-1:0] l1tol2_disp_paddr;
  // displacement ack from L2
  logic               l2tol1_dack_valid;
  logic               l2tol1_dack_retry;
  logic [L1ID_W-1:0]  l2tol1_dack_l1id;
  // sticky protocol error
  logic               err_unexp;

  // the miss port itself
  modport master (
    input  miss_valid, miss_cmd, miss_pcsign, miss_laddr, sptbr,
    output miss_retry,
    output l1tol2_req_valid, l1tol2_req_dcid, l1tol2_req_cmd, l1tol2_req_pcsign,
           l1tol2_req_laddr, l1tol2_req_sptbr,
    input  l1tol2_req_retry,
    input  l2tol1_snack_valid, l2tol1_snack_dcid, l2tol1_snack_l2id, l2tol1_snack_snack,
           l2tol1_snack_line, l2tol1_snack_paddr,
    output l2tol1_snack_retry,
    output l1tol2_snoop_ack_valid, l1tol2_snoop_ack_l2id,
    input  l1tol2_snoop_ack_retry,
    output fill_valid, fill_id, fill_snack, fill_line, fill_paddr,
    input  fill_retry,
    output snoop_inv_valid, snoop_inv_paddr,
    input  evict_valid, evict_l2id, evict_dcmd, evict_line, evict_paddr,
    output evict_retry,
    output l1tol2_disp_valid, l1tol2_disp_l1id, l1tol2_disp_l2id, l1tol2_disp_mask,
           l1tol2_disp_dcmd, l1tol2_disp_line, l1tol2_disp_paddr,
    input  l1tol2_disp_retry,
    input  l2tol1_dack_valid, l2tol1_dack_l1id,
    output l2tol1_dack_retry,
    output err_unexp
  );

  // the L1 cache and L2 pipe as seen from the miss port
  modport slave (
    output miss_valid, miss_cmd, miss_pcsign, miss_laddr, sptbr,
    input  miss_retry,
    input  l1tol2_req_valid, l1tol2_req_dcid, l1tol2_req_cmd, l1tol2_req_pcsign,
           l1tol2_req_laddr, l1tol2_req_sptbr,
    output l1tol2_req_retry,
    output l2tol1_snack_valid, l2tol1_snack_dcid, l2tol1_snack_l2id, l2tol1_snack_snack,
           l2tol1_snack_line, l2tol1_snack_paddr,
    input  l2tol1_snack_retry,
    input  l1tol2_snoop_ack_valid, l1tol2_snoop_ack_l2id,
    output l1tol2_snoop_ack_retry,
    input  fill_valid, fill_id, fill_snack, fill_line, fill_paddr,
    output fill_retry,
    input  snoop_inv_valid, snoop_inv_paddr,
    output evict_valid, evict_l2id, evict_dcmd, evict_line, evict_paddr,
    input  evict_retry,
    input  l1tol2_disp_valid, l1tol2_disp_l1id, l1tol2_disp_l2id, l1tol2_disp_mask,
           l1tol2_disp_dcmd, l1tol2_disp_line, l1tol2_disp_paddr,
    output l1tol2_disp_retry,
    output l2tol1_dack_valid, l2tol1_dack_l1id,
    input  l2tol1_dack_retry,
    input  err_unexp
  );
endinterface

// File: rtl/l1_l2_miss_port.sv
// L1-side endpoint of the L1<->L2 protocol: tracks outstanding misses by
// dcid, turns snacks into fills / reissues / snoop invalidates, and runs a
// single displacement at a time through send and dack completion.
module l1_l2_miss_port #(
  parameter int NUM_IDS = 4,
  parameter int L1ID_W  = 5,
  parameter int LADDR_W = 39,
  parameter int CMD_W   = 3,
  parameter int SNACK_W = 5,
  parameter int PC_W    = 13,
  parameter int MASK_W  = 16,
  parameter int DISP_ID = NUM_IDS
) (
  input  logic                clk,
  input  logic                reset,
  l1_l2_miss_port_if.master   bus,
  output logic [1:0]          dbg_disp_state,
  output logic [NUM_IDS-1:0]  dbg_entry_free
);
  localparam int IDX_W = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1;

  typedef enum logic [1:0] {E_FREE = 2'd0, E_PEND = 2'd1, E_SENT = 2'd2} entry_t;
  typedef enum logic [1:0] {D_IDLE = 2'd0, D_SEND = 2'd1, D_WAIT = 2'd2} disp_t;

  entry_t             ent_state  [NUM_IDS];
  logic [CMD_W-1:0]   ent_cmd    [NUM_IDS];
  logic [PC_W-1:0]    ent_pcsign [NUM_IDS];
  logic [LADDR_W-1:0] ent_laddr  [NUM_IDS];
  disp_t              disp_state;

  logic             any_free, any_pend;
  logic [IDX_W-1:0] free_idx, pend_idx;

  // Lowest FREE entry for allocation, lowest PEND entry for issue. The entry
  // currently parked on the request register is skipped so it is never
  // issued twice.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    any_pend = 1'b0;
    pend_idx = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (ent_state[i] == E_FREE) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent_state[i] == E_PEND &&
          !(bus.l1tol2_req_valid && bus.l1tol2_req_dcid == L1ID_W'(i))) begin
        any_pend = 1'b1;
        pend_idx = IDX_W'(i);
      end
    end
  end

  logic             miss_acc, req_load, req_acc, fill_done;
  logic             snack_acc, snack_snoop, snack_nack, snack_fill, snack_hit;
  logic [IDX_W-1:0] snack_idx;
  logic             snack_err, dack_ok, dack_err;

  assign bus.miss_retry         = !any_free;
  assign bus.l2tol1_snack_retry = bus.fill_valid || bus.l1tol2_snoop_ack_valid;
  assign bus.evict_retry        = (disp_state != D_IDLE);
  assign bus.l2tol1_dack_retry  = 1'b0;
  assign bus.l1tol2_disp_l1id   = L1ID_W'(DISP_ID);
  assign bus.l1tol2_disp_mask   = {MASK_W{1'b1}};

  assign miss_acc    = bus.miss_valid && !bus.miss_retry;
  assign req_acc     = bus.l1tol2_req_valid && !bus.l1tol2_req_retry;
  assign req_load    = !bus.l1tol2_req_valid || !bus.l1tol2_req_retry;
  assign fill_done   = bus.fill_valid && !bus.fill_retry;
  assign snack_acc   = bus.l2tol1_snack_valid && !bus.l2tol1_snack_retry;
  assign snack_snoop = bus.l2tol1_snack_snack[SNACK_W-1];
  assign snack_nack  = bus.l2tol1_snack_snack[SNACK_W-1:SNACK_W-2] == 2'b01;
  assign snack_fill  = bus.l2tol1_snack_snack[SNACK_W-1:SNACK_W-2] == 2'b00;
  assign snack_idx   = bus.l2tol1_snack_dcid[IDX_W-1:0];
  // dcids beyond the table never match, even if their low bits alias an entry
  assign snack_hit   = (bus.l2tol1_snack_dcid < L1ID_W'(NUM_IDS)) &&
                       (ent_state[snack_idx] == E_SENT);
  assign snack_err   = snack_acc && !snack_snoop && !snack_hit;
  assign dack_ok     = bus.l2tol1_dack_valid && disp_state == D_WAIT &&
                       bus.l2tol1_dack_l1id == L1ID_W'(DISP_ID);
  assign dack_err    = bus.l2tol1_dack_valid &&
                       (disp_state == D_IDLE || bus.l2tol1_dack_l1id != L1ID_W'(DISP_ID));

  // Miss table, request register, fill buffer and snoop buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_IDS; i++) ent_state[i] <= E_FREE;
      bus.l1tol2_req_valid       <= 1'b0;
      bus.fill_valid             <= 1'b0;
      bus.snoop_inv_valid        <= 1'b0;
      bus.l1tol2_snoop_ack_valid <= 1'b0;
    end else begin
      if (miss_acc) begin
        ent_state[free_idx]  <= E_PEND;
        ent_cmd[free_idx]    <= bus.miss_cmd;
        ent_pcsign[free_idx] <= bus.miss_pcsign;
        ent_laddr[free_idx]  <= bus.miss_laddr;
      end
      if (req_acc) ent_state[bus.l1tol2_req_dcid[IDX_W-1:0]] <= E_SENT;
      if (fill_done) ent_state[bus.fill_id[IDX_W-1:0]] <= E_FREE;
      if (snack_acc && snack_nack && snack_hit) ent_state[snack_idx] <= E_PEND;

      // Older PEND entries win; otherwise a miss accepted this cycle goes
      // straight onto the request so it appears one cycle after acceptance.
      if (req_load) begin
        if (any_pend) begin
          bus.l1tol2_req_valid  <= 1'b1;
          bus.l1tol2_req_dcid   <= L1ID_W'(pend_idx);
          bus.l1tol2_req_cmd    <= ent_cmd[pend_idx];
          bus.l1tol2_req_pcsign <= ent_pcsign[pend_idx];
          bus.l1tol2_req_laddr  <= ent_laddr[pend_idx];
          bus.l1tol2_req_sptbr  <= bus.sptbr;
        end else if (miss_acc) begin
          bus.l1tol2_req_valid  <= 1'b1;
          bus.l1tol2_req_dcid   <= L1ID_W'(free_idx);
          bus.l1tol2_req_cmd    <= bus.miss_cmd;
          bus.l1tol2_req_pcsign <= bus.miss_pcsign;
          bus.l1tol2_req_laddr  <= bus.miss_laddr;
          bus.l1tol2_req_sptbr  <= bus.sptbr;
        end else begin
          bus.l1tol2_req_valid  <= 1'b0;
        end
      end

      if (snack_acc && snack_fill && snack_hit) begin
        bus.fill_valid <= 1'b1;
        bus.fill_id    <= bus.l2tol1_snack_dcid;
        bus.fill_snack <= bus.l2tol1_snack_snack;
        bus.fill_line  <= bus.l2tol1_snack_line;
        bus.fill_paddr <= bus.l2tol1_snack_paddr;
      end else if (fill_done) begin
        bus.fill_valid <= 1'b0;
      end

      bus.snoop_inv_valid <= snack_acc && snack_snoop;
      if (snack_acc && snack_snoop) begin
        bus.snoop_inv_paddr        <= bus.l2tol1_snack_paddr;
        bus.l1tol2_snoop_ack_valid <= 1'b1;
        bus.l1tol2_snoop_ack_l2id  <= bus.l2tol1_snack_l2id;
      end else if (!bus.l1tol2_snoop_ack_retry) begin
        bus.l1tol2_snoop_ack_valid <= 1'b0;
      end
    end
  end

  // Displacement FSM: one eviction in flight from acceptance to dack.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_state            <= D_IDLE;
      bus.l1tol2_disp_valid <= 1'b0;
    end else begin
      case (disp_state)
        D_IDLE: if (bus.evict_valid) begin
          bus.l1tol2_disp_valid <= 1'b1;
          bus.l1tol2_disp_l2id  <= bus.evict_l2id;
          bus.l1tol2_disp_dcmd  <= bus.evict_dcmd;
          bus.l1tol2_disp_line  <= bus.evict_line;
          bus.l1tol2_disp_paddr <= bus.evict_paddr;
          disp_state            <= D_SEND;
        end
        D_SEND: if (!bus.l1tol2_disp_retry) begin
          bus.l1tol2_disp_valid <= 1'b0;
          disp_state            <= D_WAIT;
        end
        D_WAIT: if (dack_ok) disp_state <= D_IDLE;
        default: disp_state <= D_IDLE;
      endcase
    end
  end

  // Sticky flag for fills/NACKs to untracked dcids and stray dacks.
  always_ff @(posedge clk) begin
    if (reset) bus.err_unexp <= 1'b0;
    else if (snack_err || dack_err) bus.err_unexp <= 1'b1;
  end

  // Debug view of FSM and entry states.
  always_comb begin
    dbg_disp_state = disp_state;
    dbg_entry_free = '0;
    for (int i = 0; i < NUM_IDS; i++) dbg_entry_free[i] = (ent_state[i] == E_FREE);
  end
endmodule

// File: tb/tb_l1_l2_miss_port.sv
// Directed bench for l1_l2_miss_port: one task per scenario, inline checks.
module tb_l1_l2_miss_port;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_disp_state;
  logic [3:0] dbg_entry_free;
  int n_vec = 0;
  int n_err = 0;

  logic [511:0] line_a = {16{32'hDEADBEEF}};
  logic [511:0] line_b = {8{64'h0123456789ABCDEF}};

  l1_l2_miss_port_if bus ();

  l1_l2_miss_port dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .dbg_disp_state (dbg_disp_state),
    .dbg_entry_free (dbg_entry_free)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.miss_valid = 0; bus.miss_cmd = 0; bus.miss_pcsign = 0; bus.miss_laddr = 0;
    bus.sptbr = 38'h12_3456_789A;
    bus.l1tol2_req_retry = 0;
    bus.l2tol1_snack_valid = 0; bus.l2tol1_snack_dcid = 0; bus.l2tol1_snack_l2id = 0;
    bus.l2tol1_snack_snack = 0; bus.l2tol1_snack_line = 0; bus.l2tol1_snack_paddr = 0;
    bus.l1tol2_snoop_ack_retry = 0;
    bus.fill_retry = 0;
    bus.evict_valid = 0; bus.evict_l2id = 0; bus.evict_dcmd = 0;
    bus.evict_line = 0; bus.evict_paddr = 0;
    bus.l1tol2_disp_retry = 0;
    bus.l2tol1_dack_valid = 0; bus.l2tol1_dack_l1id = 0;
  endtask

  // driver: fill-ack snack for an id, then let the fill drain
  task automatic drive_fill(input logic [4:0] id);
    bus.l2tol1_snack_valid = 1; bus.l2tol1_snack_dcid = id;
    bus.l2tol1_snack_snack = 5'b00001; bus.l2tol1_snack_line = line_b;
    bus.l2tol1_snack_paddr = 50'h3_0000_0000 + 50'(id);
    tick();
    bus.l2tol1_snack_valid = 0;
    tick();
  endtask

  task automatic drive_miss(input logic [38:0] laddr);
    bus.miss_valid = 1; bus.miss_laddr = laddr; bus.miss_cmd = 3'd1; bus.miss_pcsign = 13'h0AB;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    n_vec++; if (bus.l1tol2_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", bus.l1tol2_req_valid); end
    n_vec++; if (bus.fill_valid !== 1'b0) begin n_err++; $display("FAIL rst_fill_valid: got %b want 0", bus.fill_valid); end
    n_vec++; if (bus.l1tol2_snoop_ack_valid !== 1'b0 || bus.snoop_inv_valid !== 1'b0) begin n_err++; $display("FAIL rst_snoop: ack %b inv %b want 0 0", bus.l1tol2_snoop_ack_valid, bus.snoop_inv_valid); end
    n_vec++; if (bus.l1tol2_disp_valid !== 1'b0) begin n_err++; $display("FAIL rst_disp_valid: got %b want 0", bus.l1tol2_disp_valid); end
    n_vec++; if (bus.err_unexp !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.err_unexp); end
    n_vec++; if (bus.miss_retry !== 1'b0 || bus.evict_retry !== 1'b0) begin n_err++; $display("FAIL rst_retry: miss %b evict %b want 0 0", bus.miss_retry, bus.evict_retry); end
    n_vec++; if (dbg_entry_free !== 4'hF || dbg_disp_state !== 2'd0) begin n_err++; $display("FAIL rst_state: free %h disp %0d want f 0", dbg_entry_free, dbg_disp_state); end
  endtask

  // T1: single miss, request, fill
  task automatic test_miss_fill();
    drive_miss(39'h1000);
    tick();
    bus.miss_valid = 0;
    n_vec++; if (bus.l1tol2_req_valid !== 1'b1 || bus.l1tol2_req_dcid !== 5'd0) begin n_err++; $display("FAIL t1_req: valid %b dcid %0d want 1 0", bus.l1tol2_req_valid, bus.l1tol2_req_dcid); end
    n_vec++; if (bus.l1tol2_req_laddr !== 39'h1000 || bus.l1tol2_req_sptbr !== 38'h12_3456_789A || bus.l1tol2_req_cmd !== 3'd1 || bus.l1tol2_req_pcsign !== 13'h0AB) begin n_err++; $display("FAIL t1_req_payload: laddr %h sptbr %h cmd %0d pc %h", bus.l1tol2_req_laddr, bus.l1tol2_req_sptbr, bus.l1tol2_req_cmd, bus.l1tol2_req_pcsign); end
    tick();
    n_vec++; if (bus.l1tol2_req_valid !== 1'b0 || dbg_entry_free !== 4'b1110) begin n_err++; $display("FAIL t1_sent: req_valid %b free %b want 0 1110", bus.l1tol2_req_valid, dbg_entry_free); end
    bus.l2tol1_snack_valid = 1; bus.l2tol1_snack_dcid = 5'd0; bus.l2tol1_snack_snack = 5'b00010;
    bus.l2tol1_snack_line = line_a; bus.l2tol1_snack_paddr = 50'h2_0000_1000;
    n_vec++; if (bus.l2tol1_snack_retry !== 1'b0) begin n_err++; $display("FAIL t1_snack_retry: got %b want 0", bus.l2tol1_snack_retry); end
    tick();
    bus.l2tol1_snack_valid = 0;
    n_vec++; if (bus.fill_valid !== 1'b1 || bus.fill_id !== 5'd0 || bus.fill_snack !== 5'b00010) begin n_err++; $display("FAIL t1_fill: valid %b id %0d snack %b want 1 0 00010", bus.fill_valid, bus.fill_id, bus.fill_snack); end
    n_vec++; if (bus.fill_line !== line_a || bus.fill_paddr !== 50'h2_0000_1000) begin n_err++; $display("FAIL t1_fill_data: line %h paddr %h", bus.fill_line, bus.fill_paddr); end
    tick();
    n_vec++; if (bus.fill_valid !== 1'b0 || dbg_entry_free !== 4'hF) begin n_err++; $display("FAIL t1_freed: fill_valid %b free %b want 0 1111", bus.fill_valid, dbg_entry_free); end
  endtask

  // T2: table full, then free one id and reuse it
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_miss(39'h2000 + 39'(i * 64));
      tick();
      n_vec++; if (bus.l1tol2_req_valid !== 1'b1 || bus.l1tol2_req_dcid !== 5'(i) || bus.l1tol2_req_laddr !== 39'h2000 + 39'(i * 64)) begin n_err++; $display("FAIL t2_req%0d: valid %b dcid %0d laddr %h", i, bus.l1tol2_req_valid, bus.l1tol2_req_dcid, bus.l1tol2_req_laddr); end
    end
    drive_miss(39'h3000);
    n_vec++; if (bus.miss_retry !== 1'b1) begin n_err++; $display("FAIL t2_full_retry: got %b want 1", bus.miss_retry); end
    tick();
    n_vec++; if (bus.miss_retry !== 1'b1 || dbg_entry_free !== 4'b0000) begin n_err++; $display("FAIL t2_full: retry %b free %b want 1 0000", bus.miss_retry, dbg_entry_free); end
    bus.l2tol1_snack_valid = 1; bus.l2tol1_snack_dcid = 5'd2; bus.l2tol1_snack_snack = 5'b00001;
    bus.l2tol1_snack_line = line_b; bus.l2tol1_snack_paddr = 50'h100;
    tick();
    bus.l2tol1_snack_valid = 0;
    n_vec++; if (bus.fill_valid !== 1'b1 || bus.fill_id !== 5'd2 || bus.miss_retry !== 1'b1) begin n_err++; $display("FAIL t2_fill2: valid %b id %0d retry %b want 1 2 1", bus.fill_valid, bus.fill_id, bus.miss_retry); end
    tick();
    n_vec++; if (bus.miss_retry !== 1'b0 || dbg_entry_free !== 4'b0100 || bus.l1tol2_req_valid !== 1'b0) begin n_err++; $display("FAIL t2_freed: retry %b free %b req %b want 0 0100 0", bus.miss_retry, dbg_entry_free, bus.l1tol2_req_valid); end
    tick();
    bus.miss_valid = 0;
    n_vec++; if (bus.l1tol2_req_valid !== 1'b1 || bus.l1tol2_req_dcid !== 5'd2 || bus.l1tol2_req_laddr !== 39'h3000) begin n_err++; $display("FAIL t2_reuse: valid %b dcid %0d laddr %h want 1 2 3000", bus.l1tol2_req_valid, bus.l1tol2_req_dcid, bus.l1tol2_req_laddr); end
    tick();
    for (int i = 0; i < 4; i++) drive_fill(5'(i));
    n_vec++; if (dbg_entry_free !== 4'hF || bus.err_unexp !== 1'b0) begin n_err++; $display("FAIL t2_drain: free %b err %b want 1111 0", dbg_entry_free, bus.err_unexp); end
  endtask

  // T3: held request payload, NACK reissue
  task automatic test_retry_nack();
    bus.l1tol2_req_retry = 1;
    drive_miss(39'h4000);
    tick();
    drive_miss(39'h5000);
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (bus.l1tol2_req_valid !== 1'b1 || bus.l1tol2_req_dcid !== 5'd0 || bus.l1tol2_req_laddr !== 39'h4000) begin n_err++; $display("FAIL t3_hold%0d: valid %b dcid %0d laddr %h want 1 0 4000", k, bus.l1tol2_req_valid, bus.l1tol2_req_dcid, bus.l1tol2_req_laddr); end
      tick();
      bus.miss_valid = 0;
    end
    bus.l1tol2_req_retry = 0;
    tick();
    n_vec++; if (bus.l1tol2_req_valid !== 1'b1 || bus.l1tol2_req_dcid !== 5'd1 || bus.l1tol2_req_laddr !== 39'h5000) begin n_err++; $display("FAIL t3_next: valid %b dcid %0d laddr %h want 1 1 5000", bus.l1tol2_req_valid, bus.l1tol2_req_dcid, bus.l1tol2_req_laddr); end
    tick();
    n_vec++; if (bus.l1tol2_req_valid !== 1'b0 || dbg_entry_free !== 4'b1100) begin n_err++; $display("FAIL t3_sent: req %b free %b want 0 1100", bus.l1tol2_req_valid, dbg_entry_free); end
    bus.l2tol1_snack_valid = 1; bus.l2tol1_snack_dcid = 5'd1; bus.l2tol1_snack_snack = 5'b01000;
    tick();
    bus.l2tol1_snack_valid = 0;
    n_vec++; if (bus.fill_valid !== 1'b0 || bus.l1tol2_req_valid !== 1'b0) begin n_err++; $display("FAIL t3_nack: fill %b req %b want 0 0", bus.fill_valid, bus.l1tol2_req_valid); end
    tick();
    n_vec++; if (bus.l1tol2_req_valid !== 1'b1 || bus.l1tol2_req_dcid !== 5'd1 || bus.l1tol2_req_laddr !== 39'h5000) begin n_err++; $display("FAIL t3_reissue: valid %b dcid %0d laddr %h want 1 1 5000", bus.l1tol2_req_valid, bus.l1tol2_req_dcid, bus.l1tol2_req_laddr); end
    tick();
    drive_fill(5'd0);
    drive_fill(5'd1);
    n_vec++; if (dbg_entry_free !== 4'hF || bus.err_unexp !== 1'b0) begin n_err++; $display("FAIL t3_drain: free %b err %b want 1111 0", dbg_entry_free, bus.err_unexp); end
  endtask

  // T4: snoop with ack backpressure
  task automatic test_snoop();
    bus.l1tol2_snoop_ack_retry = 1;
    bus.l2tol1_snack_valid = 1; bus.l2tol1_snack_snack = 5'b10000;
    bus.l2tol1_snack_l2id = 6'h2A; bus.l2tol1_snack_paddr = 50'hA_BC00;
    tick();
    bus.l2tol1_snack_valid = 0;
    n_vec++; if (bus.snoop_inv_valid !== 1'b1 || bus.snoop_inv_paddr !== 50'hA_BC00) begin n_err++; $display("FAIL t4_inv: valid %b paddr %h want 1 abc00", bus.snoop_inv_valid, bus.snoop_inv_paddr); end
    n_vec++; if (bus.l1tol2_snoop_ack_valid !== 1'b1 || bus.l1tol2_snoop_ack_l2id !== 6'h2A || bus.l2tol1_snack_retry !== 1'b1) begin n_err++; $display("FAIL t4_ack: valid %b l2id %h snack_retry %b want 1 2a 1", bus.l1tol2_snoop_ack_valid, bus.l1tol2_snoop_ack_l2id, bus.l2tol1_snack_retry); end
    tick();
    n_vec++; if (bus.snoop_inv_valid !== 1'b0 || bus.l1tol2_snoop_ack_valid !== 1'b1 || bus.l2tol1_snack_retry !== 1'b1) begin n_err++; $display("FAIL t4_held: inv %b ack %b snack_retry %b want 0 1 1", bus.snoop_inv_valid, bus.l1tol2_snoop_ack_valid, bus.l2tol1_snack_retry); end
    bus.l1tol2_snoop_ack_retry = 0;
    tick();
    n_vec++; if (bus.snoop_inv_valid !== 1'b0 || bus.l1tol2_snoop_ack_valid !== 1'b0 || bus.l2tol1_snack_retry !== 1'b0) begin n_err++; $display("FAIL t4_done: inv %b ack %b snack_retry %b want 0 0 0", bus.snoop_inv_valid, bus.l1tol2_snoop_ack_valid, bus.l2tol1_snack_retry); end
  endtask

  // T5: displacement, blocked second evict, dack checking
  task automatic test_evict_disp();
    bus.evict_valid = 1; bus.evict_l2id = 6'h11; bus.evict_dcmd = 3'd2;
    bus.evict_line = line_a; bus.evict_paddr = 50'h7_7000;
    bus.l1tol2_disp_retry = 1;
    n_vec++; if (bus.evict_retry !== 1'b0) begin n_err++; $display("FAIL t5_idle_retry: got %b want 0", bus.evict_retry); end
    tick();
    bus.evict_l2id = 6'h22; bus.evict_line = line_b; bus.evict_paddr = 50'h8_8000;
    n_vec++; if (bus.l1tol2_disp_valid !== 1'b1 || bus.l1tol2_disp_l1id !== 5'd4 || bus.l1tol2_disp_l2id !== 6'h11 || bus.l1tol2_disp_mask !== 16'hFFFF || bus.l1tol2_disp_dcmd !== 3'd2) begin n_err++; $display("FAIL t5_disp: valid %b l1id %0d l2id %h mask %h dcmd %0d", bus.l1tol2_disp_valid, bus.l1tol2_disp_l1id, bus.l1tol2_disp_l2id, bus.l1tol2_disp_mask, bus.l1tol2_disp_dcmd); end
    n_vec++; if (bus.l1tol2_disp_line !== line_a || bus.l1tol2_disp_paddr !== 50'h7_7000 || bus.evict_retry !== 1'b1) begin n_err++; $display("FAIL t5_disp_data: paddr %h evict_retry %b", bus.l1tol2_disp_paddr, bus.evict_retry); end
    tick();
    bus.l1tol2_disp_retry = 0;
    n_vec++; if (bus.l1tol2_disp_valid !== 1'b1 || bus.l1tol2_disp_l2id !== 6'h11 || dbg_disp_state !== 2'd1) begin n_err++; $display("FAIL t5_disp_hold: valid %b l2id %h state %0d want 1 11 1", bus.l1tol2_disp_valid, bus.l1tol2_disp_l2id, dbg_disp_state); end
    tick();
    bus.l2tol1_dack_valid = 1; bus.l2tol1_dack_l1id = 5'd2;
    n_vec++; if (bus.l1tol2_disp_valid !== 1'b0 || dbg_disp_state !== 2'd2 || bus.evict_retry !== 1'b1) begin n_err++; $display("FAIL t5_wait: valid %b state %0d evict_retry %b want 0 2 1", bus.l1tol2_disp_valid, dbg_disp_state, bus.evict_retry); end
    tick();
    bus.l2tol1_dack_l1id = 5'd4;
    n_vec++; if (bus.err_unexp !== 1'b1 || dbg_disp_state !== 2'd2) begin n_err++; $display("FAIL t5_bad_dack: err %b state %0d want 1 2", bus.err_unexp, dbg_disp_state); end
    tick();
    bus.l2tol1_dack_valid = 0;
    n_vec++; if (dbg_disp_state !== 2'd0 || bus.evict_retry !== 1'b0) begin n_err++; $display("FAIL t5_dack: state %0d evict_retry %b want 0 0", dbg_disp_state, bus.evict_retry); end
    tick();
    bus.evict_valid = 0;
    n_vec++; if (bus.l1tol2_disp_valid !== 1'b1 || bus.l1tol2_disp_l2id !== 6'h22 || bus.l1tol2_disp_paddr !== 50'h8_8000) begin n_err++; $display("FAIL t5_second: valid %b l2id %h paddr %h want 1 22 88000", bus.l1tol2_disp_valid, bus.l1tol2_disp_l2id, bus.l1tol2_disp_paddr); end
    tick();
    n_vec++; if (dbg_disp_state !== 2'd2) begin n_err++; $display("FAIL t5_second_wait: state %0d want 2", dbg_disp_state); end
  endtask

  // T6: reset with live entries, a buffered fill and disp in D_WAIT
  task automatic test_reset_mid();
    drive_miss(39'h6000);
    tick();
    drive_miss(39'h6040);
    tick();
    bus.miss_valid = 0;
    tick();
    n_vec++; if (dbg_entry_free !== 4'b1100) begin n_err++; $display("FAIL t6_setup: free %b want 1100", dbg_entry_free); end
    bus.fill_retry = 1;
    bus.l2tol1_snack_valid = 1; bus.l2tol1_snack_dcid = 5'd0; bus.l2tol1_snack_snack = 5'b00000;
    tick();
    bus.l2tol1_snack_valid = 0;
    n_vec++; if (bus.fill_valid !== 1'b1) begin n_err++; $display("FAIL t6_fill_held: got %b want 1", bus.fill_valid); end
    reset = 1;
    tick();
    reset = 0;
    bus.fill_retry = 0;
    n_vec++; if (bus.fill_valid !== 1'b0 || bus.l1tol2_req_valid !== 1'b0 || bus.l1tol2_disp_valid !== 1'b0 || bus.l1tol2_snoop_ack_valid !== 1'b0) begin n_err++; $display("FAIL t6_valids: fill %b req %b disp %b ack %b want 0", bus.fill_valid, bus.l1tol2_req_valid, bus.l1tol2_disp_valid, bus.l1tol2_snoop_ack_valid); end
    n_vec++; if (dbg_entry_free !== 4'hF || dbg_disp_state !== 2'd0 || bus.err_unexp !== 1'b0 || bus.miss_retry !== 1'b0 || bus.evict_retry !== 1'b0) begin n_err++; $display("FAIL t6_state: free %b disp %0d err %b mr %b er %b", dbg_entry_free, dbg_disp_state, bus.err_unexp, bus.miss_retry, bus.evict_retry); end
    tick(); tick();
    n_vec++; if (bus.l1tol2_req_valid !== 1'b0 || bus.fill_valid !== 1'b0) begin n_err++; $display("FAIL t6_no_resend: req %b fill %b want 0 0", bus.l1tol2_req_valid, bus.fill_valid); end
    // stray fill to a FREE id after reset is flagged
    drive_fill(5'd3);
    n_vec++; if (bus.err_unexp !== 1'b1 || bus.fill_valid !== 1'b0) begin n_err++; $display("FAIL t6_stray_fill: err %b fill %b want 1 0", bus.err_unexp, bus.fill_valid); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_miss_fill();
    test_back_to_back();
    test_retry_nack();
    test_snoop();
    test_evict_disp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
